// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for the two-wide instruction queue.
// master: the fetch + decode environment (drives enq_* and deq_ack*).
// slave : the queue itself (drives enq_ready, deq_*, count).
interface inst_queue_if #(
    parameter int PTR_W    = 3,
    parameter int INSN_LEN = 32,
    parameter int ADDR_LEN = 32
);
    logic                enq_valid1;
    logic                enq_valid2;
    logic [INSN_LEN-1:0] enq_inst1;
    logic [INSN_LEN-1:0] enq_inst2;
    logic [ADDR_LEN-1:0] enq_pc1;
    logic [ADDR_LEN-1:0] enq_pc2;
    logic                enq_ready;
    logic                deq_valid1;
    logic                deq_valid2;
    logic [INSN_LEN-1:0] deq_inst1;
    logic [INSN_LEN-1:0] deq_inst2;
    logic [ADDR_LEN-1:0] deq_pc1;
    logic [ADDR_LEN-1:0] deq_pc2;
    logic                deq_ack1;
    logic                deq_ack2;
    logic [PTR_W:0]      count;

    modport master (
        output enq_valid1, enq_valid2, enq_inst1, enq_inst2, enq_pc1, enq_pc2,
        output deq_ack1, deq_ack2,
        input  enq_ready, deq_valid1, deq_valid2, deq_inst1, deq_inst2,
        input  deq_pc1, deq_pc2, count
    );

    modport slave (
        input  enq_valid1, enq_valid2, enq_inst1, enq_inst2, enq_pc1, enq_pc2,
        input  deq_ack1, deq_ack2,
        output enq_ready, deq_valid1, deq_valid2, deq_inst1, deq_inst2,
        output deq_pc1, deq_pc2, count
    );
endinterface

// File: rtl/inst_queue.sv
// Two-wide circular instruction buffer between fetch and decode.
// Latency: enqueue in cycle N is visible on deq outputs in N+1 (no bypass).
// Backpressure: enq_ready drops when fewer than two entries are free; fetch holds its inputs.
// Ports: clk, reset (sync, active-high), flush (discard all entries),
//        q (slave side of inst_queue_if: enq pair in, deq pair out, acks, count).
module inst_queue #(
    parameter int ENTRIES  = 8,
    parameter int PTR_W    = 3,
    parameter int INSN_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    inst_queue_if.slave q
);
    logic [INSN_LEN-1:0] r_inst [ENTRIES];
    logic [ADDR_LEN-1:0] r_pc   [ENTRIES];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [PTR_W:0]      r_count;

    logic                w_enq_ready;
    logic                w_deq_valid1;
    logic                w_deq_valid2;
    logic                w_enq_fire;
    logic                w_ack1;
    logic                w_ack2;
    logic [PTR_W:0]      w_enq_n;
    logic [PTR_W:0]      w_deq_n;
    logic [PTR_W-1:0]    w_head1;
    logic [PTR_W-1:0]    w_tail1;
    logic                w_clear;

    // Status depends only on registered count, so there is no input-to-output path
    // and enqueue eligibility always sees the pre-dequeue occupancy.
    assign w_enq_ready  = (r_count <= (PTR_W+1)'(ENTRIES - 2));
    assign w_deq_valid1 = (r_count != '0);
    assign w_deq_valid2 = (r_count >= (PTR_W+1)'(2));

    // Power-of-two depth: pointer wrap falls out of the natural PTR_W-bit overflow.
    assign w_head1 = r_head + PTR_W'(1);
    assign w_tail1 = r_tail + PTR_W'(1);

    // A lone slot-2 valid is dropped because fire requires slot 1.
    assign w_enq_fire = w_enq_ready && q.enq_valid1;
    assign w_enq_n    = !w_enq_fire ? '0 : (q.enq_valid2 ? (PTR_W+1)'(2) : (PTR_W+1)'(1));

    // Acks only count against valid outputs, and ack2 requires ack1 (in-order retire).
    assign w_ack1  = q.deq_ack1 && w_deq_valid1;
    assign w_ack2  = q.deq_ack2 && w_deq_valid2 && w_ack1;
    assign w_deq_n = (PTR_W+1)'({1'b0, w_ack1} + {1'b0, w_ack2});

    assign w_clear = reset || flush;

    // Storage has no reset; stale contents are hidden by the output zero-forcing.
    always_ff @(posedge clk) begin
        if (!w_clear && w_enq_fire) begin
            r_inst[r_tail] <= q.enq_inst1;
            r_pc[r_tail]   <= q.enq_pc1;
            if (q.enq_valid2) begin
                r_inst[w_tail1] <= q.enq_inst2;
                r_pc[w_tail1]   <= q.enq_pc2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_deq_n[PTR_W-1:0];
            r_tail  <= r_tail + w_enq_n[PTR_W-1:0];
            r_count <= r_count + w_enq_n - w_deq_n;
        end
    end

    assign q.enq_ready  = w_enq_ready;
    assign q.deq_valid1 = w_deq_valid1;
    assign q.deq_valid2 = w_deq_valid2;
    assign q.deq_inst1  = w_deq_valid1 ? r_inst[r_head]  : '0;
    assign q.deq_pc1    = w_deq_valid1 ? r_pc[r_head]    : '0;
    assign q.deq_inst2  = w_deq_valid2 ? r_inst[w_head1] : '0;
    assign q.deq_pc2    = w_deq_valid2 ? r_pc[w_head1]   : '0;
    assign q.count      = r_count;
endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    localparam int ENTRIES = 8;
    localparam int PTR_W   = 3;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    inst_queue_if #(.PTR_W(PTR_W), .INSN_LEN(32), .ADDR_LEN(32)) q_if ();

    inst_queue #(.ENTRIES(ENTRIES), .PTR_W(PTR_W), .INSN_LEN(32), .ADDR_LEN(32)) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .q    (q_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a plain FIFO of {inst, pc} records.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        bit          fl, v1, v2, a1, a2;
        logic [31:0] pc1, pc2;
        int          ec;
        bit          er, ev1, ev2;
        logic [31:0] ep1, ep2;
    } vec_t;
    vec_t tbl[$];

    // Deterministic instruction word for a given PC (test-plan words for 0x100/0x104).
    function automatic logic [31:0] ifn(logic [31:0] pc);
        if (pc == 32'h100) return 32'h00500093;
        if (pc == 32'h104) return 32'h00a00113;
        return {pc[15:0], 16'h0093};
    endfunction

    function automatic vec_t mk(bit fl, bit v1, bit v2, logic [31:0] p1, logic [31:0] p2,
                                bit a1, bit a2, int ec, bit er, bit ev1, bit ev2,
                                logic [31:0] ep1, logic [31:0] ep2);
        vec_t v;
        v.fl = fl; v.v1 = v1; v.v2 = v2; v.pc1 = p1; v.pc2 = p2; v.a1 = a1; v.a2 = a2;
        v.ec = ec; v.er = er; v.ev1 = ev1; v.ev2 = ev2; v.ep1 = ep1; v.ep2 = ep2;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int ec, bit er, bit ev1, bit ev2,
                           logic [31:0] ep1, logic [31:0] ei1,
                           logic [31:0] ep2, logic [31:0] ei2);
        chk({tag, " count"},      32'(q_if.count),      32'(ec));
        chk({tag, " enq_ready"},  32'(q_if.enq_ready),  32'(er));
        chk({tag, " deq_valid1"}, 32'(q_if.deq_valid1), 32'(ev1));
        chk({tag, " deq_valid2"}, 32'(q_if.deq_valid2), 32'(ev2));
        chk({tag, " deq_pc1"},    q_if.deq_pc1,   ep1);
        chk({tag, " deq_inst1"},  q_if.deq_inst1, ei1);
        chk({tag, " deq_pc2"},    q_if.deq_pc2,   ep2);
        chk({tag, " deq_inst2"},  q_if.deq_inst2, ei2);
    endtask

    task automatic chk_model(string tag);
        int          n;
        logic [31:0] p1, i1, p2, i2;
        n  = mq.size();
        p1 = (n >= 1) ? mq[0].pc   : 32'h0;
        i1 = (n >= 1) ? mq[0].inst : 32'h0;
        p2 = (n >= 2) ? mq[1].pc   : 32'h0;
        i2 = (n >= 2) ? mq[1].inst : 32'h0;
        chk_all(tag, n, (ENTRIES - n) >= 2, n >= 1, n >= 2, p1, i1, p2, i2);
    endtask

    task automatic drive(bit fl, bit v1, bit v2, logic [31:0] p1, logic [31:0] p2,
                         bit a1, bit a2);
        flush           = fl;
        q_if.enq_valid1 = v1;
        q_if.enq_valid2 = v2;
        q_if.enq_pc1    = p1;
        q_if.enq_pc2    = p2;
        q_if.enq_inst1  = ifn(p1);
        q_if.enq_inst2  = ifn(p2);
        q_if.deq_ack1   = a1;
        q_if.deq_ack2   = a2;
    endtask

    // Advance the model from the inputs being presented, then clock the DUT.
    task automatic tick();
        int   n, d;
        ent_t e;
        if (reset || flush) begin
            mq.delete();
        end else begin
            n = mq.size();
            d = 0;
            if (q_if.deq_ack1 && n >= 1) begin
                d = 1;
                if (q_if.deq_ack2 && n >= 2) d = 2;
            end
            repeat (d) void'(mq.pop_front());
            if ((ENTRIES - n) >= 2 && q_if.enq_valid1) begin
                e.pc = q_if.enq_pc1; e.inst = q_if.enq_inst1;
                mq.push_back(e);
                if (q_if.enq_valid2) begin
                    e.pc = q_if.enq_pc2; e.inst = q_if.enq_inst2;
                    mq.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_all("reset", 0, 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("idle%0d", i), 0, 1, 0, 0, 0, 0, 0, 0);
        end

        // fl v1 v2 pc1 pc2 a1 a2 | count ready dv1 dv2 pc1 pc2
        tbl.push_back(mk(0,0,0,0,0,0,0,             0,1,0,0,0,0));
        tbl.push_back(mk(0,1,1,'h100,'h104,0,0,     2,1,1,1,'h100,'h104));
        tbl.push_back(mk(0,0,0,0,0,1,1,             0,1,0,0,0,0));
        tbl.push_back(mk(0,1,1,'h400,'h404,0,0,     2,1,1,1,'h400,'h404));
        tbl.push_back(mk(0,1,1,'h408,'h40c,0,0,     4,1,1,1,'h400,'h404));
        tbl.push_back(mk(0,1,1,'h410,'h414,0,0,     6,1,1,1,'h400,'h404));
        tbl.push_back(mk(0,1,1,'h418,'h41c,0,0,     8,0,1,1,'h400,'h404));
        tbl.push_back(mk(0,1,1,'h420,'h424,0,0,     8,0,1,1,'h400,'h404));
        tbl.push_back(mk(0,1,1,'h420,'h424,1,0,     7,0,1,1,'h404,'h408));
        tbl.push_back(mk(0,1,1,'h420,'h424,0,0,     7,0,1,1,'h404,'h408));
        tbl.push_back(mk(0,0,0,0,0,1,1,             5,1,1,1,'h40c,'h410));
        tbl.push_back(mk(0,0,0,0,0,1,1,             3,1,1,1,'h414,'h418)); // head=7 reads 7,0
        tbl.push_back(mk(0,0,0,0,0,1,1,             1,1,1,0,'h41c,0));
        tbl.push_back(mk(0,1,1,'h500,'h504,0,0,     3,1,1,1,'h41c,'h500));
        tbl.push_back(mk(0,1,1,'h508,'h50c,1,0,     4,1,1,1,'h500,'h504));
        tbl.push_back(mk(0,0,0,0,0,1,0,             3,1,1,1,'h504,'h508));
        tbl.push_back(mk(0,0,0,0,0,1,0,             2,1,1,1,'h508,'h50c));
        tbl.push_back(mk(0,0,0,0,0,1,0,             1,1,1,0,'h50c,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,             0,1,0,0,0,0));
        tbl.push_back(mk(0,1,0,'h600,0,0,0,         1,1,1,0,'h600,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,             0,1,0,0,0,0));
        tbl.push_back(mk(0,1,1,'h200,'h204,0,0,     2,1,1,1,'h200,'h204)); // tail=7 writes 7,0
        tbl.push_back(mk(0,0,0,0,0,1,1,             0,1,0,0,0,0));
        tbl.push_back(mk(0,1,1,'h700,'h704,0,0,     2,1,1,1,'h700,'h704));
        tbl.push_back(mk(0,1,1,'h708,'h70c,0,0,     4,1,1,1,'h700,'h704));
        tbl.push_back(mk(0,1,0,'h710,0,0,0,         5,1,1,1,'h700,'h704));
        tbl.push_back(mk(1,1,1,'h720,'h724,1,1,     0,1,0,0,0,0));
        tbl.push_back(mk(0,1,0,'h300,0,0,0,         1,1,1,0,'h300,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,             0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,             0,1,0,0,0,0));
        tbl.push_back(mk(0,0,1,'h800,'h804,0,0,     0,1,0,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].v1, tbl[i].v2, tbl[i].pc1, tbl[i].pc2, tbl[i].a1, tbl[i].a2);
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].ec, tbl[i].er, tbl[i].ev1, tbl[i].ev2,
                    tbl[i].ep1, tbl[i].ev1 ? ifn(tbl[i].ep1) : 32'h0,
                    tbl[i].ep2, tbl[i].ev2 ? ifn(tbl[i].ep2) : 32'h0);
        end

        // No bypass: an enqueue being presented must not show up combinationally.
        drive(0, 1, 1, 'h900, 'h904, 1, 1);
        #1;
        chk("nobypass deq_valid1", 32'(q_if.deq_valid1), 32'h0);
        tick();
        chk_all("nobypass next", 2, 1, 1, 1, 'h900, ifn('h900), 'h904, ifn('h904));

        // Reset mid-operation with concurrent enqueue and dual ack.
        drive(0, 1, 1, 'h908, 'h90c, 0, 0);
        tick();
        reset = 1'b1;
        drive(0, 1, 1, 'h910, 'h914, 1, 1);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_all("midreset", 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk_model("post_reset");

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom & 32'hffff_fffc,
                  $urandom & 32'hffff_fffc,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1);
            tick();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_queue.md
# inst_queue

Two-wide instruction buffer between the fetch stage and the decode stage. It sits directly upstream of decode and immediate generation. It absorbs up to two fetched instructions per cycle, each with its PC, into a circular queue. It presents the oldest one or two to decode in program order. Fetch stalls and branch-mispredict flushes are decoupled from decode.

## Interface
Parameters:
- ENTRIES, 8: queue depth; power of two, ≥ 4.
- PTR_W, 3: log2(ENTRIES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (mispredict/exception redirect).
- enq_valid1  in  1  slot-1 fetch instruction present.
- enq_valid2  in  1  slot-2 fetch instruction present; legal only with enq_valid1.
- enq_inst1, enq_inst2  in  `INSN_LEN` each  instruction words; slot 1 is older.
- enq_pc1, enq_pc2  in  `ADDR_LEN` each  PCs of those instructions.
- enq_ready  out  1  at least two free entries.
- deq_valid1, deq_valid2  out  1 each  head / head+1 entry valid.
- deq_inst1, deq_inst2  out  `INSN_LEN` each  head / head+1 instruction.
- deq_pc1, deq_pc2  out  `ADDR_LEN` each  head / head+1 PC.
- deq_ack1, deq_ack2  in  1 each  decode consumes head / head+1; ack2 legal only with ack1.
- count  out  PTR_W+1  number of occupied entries.

## Operation
- State:
  - Storage array of {inst, pc}.
  - head and tail pointers, PTR_W bits each, wrapping modulo ENTRIES.
  - count register, 0..ENTRIES.
- Enqueue:
  - Accepted when enq_ready && enq_valid1.
  - Writes slot 1 at tail, and slot 2 at tail+1 if enq_valid2.
  - tail advances by 1 or 2.
  - If enq_ready is low, the input is ignored. Fetch must hold it.
  - enq_valid2 without enq_valid1 is ignored entirely.
- Dequeue:
  - Effective ack1 = deq_ack1 && deq_valid1.
  - Effective ack2 = deq_ack2 && deq_valid2 && effective ack1.
  - head advances by the number of effective acks.
  - Acks on invalid outputs are ignored.
- Combined update: count_next = count + enq_n − deq_n.
  - Simultaneous enqueue and dequeue in one cycle is legal and performed together.
  - Enqueue eligibility uses the pre-dequeue count, because enq_ready is registered-state based.
- Outputs are combinational from registers only, with no input-to-output path:
  - enq_ready = (ENTRIES − count) ≥ 2.
  - deq_valid1 = count ≥ 1.
  - deq_valid2 = count ≥ 2.
  - deq_inst/deq_pc of each slot read storage at head / head+1 (mod ENTRIES), and are forced to 0 when that slot's valid is low.
- Flush:
  - head, tail and count are cleared to 0.
  - Same-cycle enqueue and dequeue are discarded; flush has priority.
- Reset:
  - Same effect as flush.
  - Storage contents are not cleared; they are unobservable because outputs are zero-forced.
- Reset values: count=0, enq_ready=1, deq_valid1=0, deq_valid2=0, all deq_inst/deq_pc=0.

## Timing
- Latency: an instruction enqueued in cycle N appears on deq outputs in cycle N+1 at the earliest. There is no bypass.
- Throughput: 2 in and 2 out per cycle sustained.
- Full boundary:
  - With count = ENTRIES−1 or ENTRIES, enq_ready=0 even if a dequeue happens that cycle.
  - enq_ready rises the cycle after count drops to ≤ ENTRIES−2.
- Empty boundary: with count=0, both deq_valid are 0 and any acks are ignored.
- Wrap-around:
  - Pointer arithmetic wraps; a 2-wide write at tail=ENTRIES−1 writes entries ENTRIES−1 and 0.
  - A 2-wide read at head=ENTRIES−1 likewise reads entries ENTRIES−1 and 0.
- Flush mid-stream: the cycle after flush, count=0 and deq_valid1=0, regardless of concurrent enq/ack.
- Reset mid-operation: identical to flush; takes priority over everything.

## Test plan
- Reset then idle:
  - Expect count=0, enq_ready=1, deq_valid1/2=0, deq_inst1=0 on every cycle.
- Enqueue pair, pc1=0x100 inst1=0x00500093, pc2=0x104 inst2=0x00a00113:
  - Next cycle deq_valid1/2=1 with those values in order.
  - ack both: next cycle count=0.
- Fill to count=7 by four cycles of pairs (8) then one ack1:
  - enq_ready=0 at count=8 and at count=7.
  - Enqueue attempts are ignored and count stays.
  - ack2 (dual ack): count 7→5, enq_ready=1 next cycle.
- Wrap-around: advance head/tail to 7, enqueue pair 0x200/0x204:
  - Storage entries 7 and 0 are written.
  - Dequeue yields 0x200 then 0x204 in the same cycle.
- Simultaneous enq pair and ack1 at count=3: count becomes 4. Order is preserved over 4 subsequent single acks.
- Flush with concurrent enq pair and ack2 at count=5:
  - Next cycle count=0, deq_valid1=0.
  - A later enqueue of pc 0x300 appears first at deq_pc1.
